// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants and types for the writeback stage.
//   - Datapath and register-address widths.
//   - Load funct3 encodings (LB .. LWU; 3'b111 is treated as LD).
//   - Writeback entry state encoding.
package wb_stage_pkg;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        WB_EMPTY   = 2'd0,
        WB_WAIT_LD = 2'd1,
        WB_RDY     = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// wb_load_align: combinational load formatter.
//   raw_i    : raw XLEN-bit load word
//   off_i    : byte offset of the load inside the word
//   funct3_i : load size/sign encoding
//   data_o   : word shifted down by the offset, then sign/zero-extended
// Misaligned offsets are not checked; bytes shifted in from the top are zero.
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int XW = XLEN
) (
    input  logic [XW-1:0] raw_i,
    input  logic [2:0]    off_i,
    input  logic [2:0]    funct3_i,
    output logic [XW-1:0] data_o
);

    logic [XW-1:0] shifted;

    always_comb begin
        shifted = raw_i >> {off_i, 3'b000};
        data_o  = shifted;
        case (funct3_i)
            F3_LB:   data_o = {{(XW-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   data_o = {{(XW-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{(XW-32){shifted[31]}}, shifted[31:0]};
            F3_LBU:  data_o = {{(XW-8){1'b0}},         shifted[7:0]};
            F3_LHU:  data_o = {{(XW-16){1'b0}},        shifted[15:0]};
            F3_LWU:  data_o = {{(XW-32){1'b0}},        shifted[31:0]};
            default: data_o = shifted; // LD and the unused 3'b111 encoding
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the NPC pipeline, feeding the regfile write port.
//   clk, rst_n           : clock, asynchronous active-low reset
//   mem_*                : instruction from the memory stage (valid/ready handshake)
//   ld_rvalid_i/rdata_i  : late load data strobe and raw 64-bit word
//   wr_addr/data/en_o    : register file write port
//   byp_valid/addr/data_o: decode bypass, identical to the write port
// Optional macro WB_COMMIT_TRACE_EN adds commit_valid_o, commit_pc_o and
// instret_o (retire pulse, retiring PC, 64-bit retired-instruction count).
//
// One-entry buffer: an entry is written in the cycle it sits in RDY, so a new
// accept can overlap the retire and back-to-back instructions flow at one per
// cycle. Only a load still waiting for data (WAIT_LD) stalls the memory stage.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN    = wb_stage_pkg::XLEN,
    parameter int RADDR_W = wb_stage_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_valid_i,
    output logic               mem_ready_o,
    input  logic [RADDR_W-1:0] mem_rd_i,
    input  logic               mem_rd_wen_i,
    input  logic               mem_is_load_i,
    input  logic [2:0]         mem_funct3_i,
    input  logic [2:0]         mem_off_i,
    input  logic [XLEN-1:0]    mem_alu_i,
    input  logic [XLEN-1:0]    mem_pc_i,
    input  logic               ld_rvalid_i,
    input  logic [XLEN-1:0]    ld_rdata_i,
    output logic [RADDR_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]    wr_data_o,
    output logic               wr_en_o,
    output logic               byp_valid_o,
    output logic [RADDR_W-1:0] byp_addr_o,
    output logic [XLEN-1:0]    byp_data_o
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic               commit_valid_o,
    output logic [XLEN-1:0]    commit_pc_o,
    output logic [63:0]        instret_o
`endif
);

    wb_state_e          state_q, state_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               rd_wen_q, rd_wen_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [2:0]         off_q, off_d;
    logic [XLEN-1:0]    data_q, data_d;

    logic               accept;
    logic               retire;
    logic [2:0]         align_off;
    logic [2:0]         align_funct3;
    logic [XLEN-1:0]    align_data;

    // A waiting load formats with its held size/offset; otherwise the
    // formatter serves a load whose data arrives together with the accept.
    assign align_off    = (state_q == WB_WAIT_LD) ? off_q    : mem_off_i;
    assign align_funct3 = (state_q == WB_WAIT_LD) ? funct3_q : mem_funct3_i;

    wb_load_align #(.XW(XLEN)) u_align (
        .raw_i    (ld_rdata_i),
        .off_i    (align_off),
        .funct3_i (align_funct3),
        .data_o   (align_data)
    );

    assign mem_ready_o = (state_q != WB_WAIT_LD);
    assign accept      = mem_valid_i & mem_ready_o;
    assign retire      = (state_q == WB_RDY);

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        rd_wen_d = rd_wen_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        data_d   = data_q;

        case (state_q)
            WB_WAIT_LD: begin
                if (ld_rvalid_i) begin
                    data_d  = align_data;
                    state_d = WB_RDY;
                end
            end
            WB_RDY:  state_d = WB_EMPTY; // retires this cycle regardless
            default: state_d = WB_EMPTY;
        endcase

        // Never true in WAIT_LD, so it cannot clobber a waiting load.
        if (accept) begin
            rd_d     = mem_rd_i;
            rd_wen_d = mem_rd_wen_i;
            funct3_d = mem_funct3_i;
            off_d    = mem_off_i;
            if (!mem_is_load_i) begin
                data_d  = mem_alu_i;
                state_d = WB_RDY;
            end else if (ld_rvalid_i) begin
                data_d  = align_data;
                state_d = WB_RDY;
            end else begin
                data_d  = '0;
                state_d = WB_WAIT_LD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WB_EMPTY;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            rd_wen_q <= rd_wen_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            data_q   <= data_d;
        end
    end

    // x0 writes still retire but never reach the regfile or bypass.
    assign wr_en_o     = retire & rd_wen_q & (rd_q != '0);
    assign wr_addr_o   = rd_q;
    assign wr_data_o   = data_q;
    assign byp_valid_o = wr_en_o;
    assign byp_addr_o  = rd_q;
    assign byp_data_o  = data_q;

`ifdef WB_COMMIT_TRACE_EN
    logic [XLEN-1:0] pc_q, pc_d;
    logic [63:0]     instret_q, instret_d;

    always_comb begin
        pc_d      = accept ? mem_pc_i : pc_q;
        instret_d = retire ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign commit_valid_o = retire;
    assign commit_pc_o    = pc_q;
    assign instret_o      = instret_q;
`else
    logic unused_pc;
    assign unused_pc = ^mem_pc_i;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic        mem_rd_wen_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [2:0]  mem_off_i;
    logic [63:0] mem_alu_i;
    logic [63:0] mem_pc_i;
    logic        ld_rvalid_i;
    logic [63:0] ld_rdata_i;
    logic [4:0]  wr_addr_o;
    logic [63:0] wr_data_o;
    logic        wr_en_o;
    logic        byp_valid_o;
    logic [4:0]  byp_addr_o;
    logic [63:0] byp_data_o;
`ifdef WB_COMMIT_TRACE_EN
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic [63:0] instret_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_rd_i     (mem_rd_i),
        .mem_rd_wen_i (mem_rd_wen_i),
        .mem_is_load_i(mem_is_load_i),
        .mem_funct3_i (mem_funct3_i),
        .mem_off_i    (mem_off_i),
        .mem_alu_i    (mem_alu_i),
        .mem_pc_i     (mem_pc_i),
        .ld_rvalid_i  (ld_rvalid_i),
        .ld_rdata_i   (ld_rdata_i),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .wr_en_o      (wr_en_o),
        .byp_valid_o  (byp_valid_o),
        .byp_addr_o   (byp_addr_o),
        .byp_data_o   (byp_data_o)
`ifdef WB_COMMIT_TRACE_EN
        ,
        .commit_valid_o(commit_valid_o),
        .commit_pc_o   (commit_pc_o),
        .instret_o     (instret_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full write + bypass port check.
    task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [63:0] d);
        chk({tag, ".wr_en"}, {63'd0, wr_en_o}, {63'd0, en});
        chk({tag, ".byp_valid"}, {63'd0, byp_valid_o}, {63'd0, en});
        if (en) begin
            chk({tag, ".wr_addr"}, {59'd0, wr_addr_o}, {59'd0, a});
            chk({tag, ".wr_data"}, wr_data_o, d);
            chk({tag, ".byp_addr"}, {59'd0, byp_addr_o}, {59'd0, a});
            chk({tag, ".byp_data"}, byp_data_o, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid_i   = 1'b0;
        mem_is_load_i = 1'b0;
        ld_rvalid_i   = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rd, input logic wen, input logic ld,
                         input logic [2:0] f3, input logic [2:0] off, input logic [63:0] alu);
        mem_valid_i   = 1'b1;
        mem_rd_i      = rd;
        mem_rd_wen_i  = wen;
        mem_is_load_i = ld;
        mem_funct3_i  = f3;
        mem_off_i     = off;
        mem_alu_i     = alu;
        mem_pc_i      = 64'h1000 + {59'd0, rd, 2'b00};
    endtask

    // Same-cycle load formatting vectors: funct3, offset, raw word, expected.
    logic [2:0]  lv_f3  [7] = '{3'b010, 3'b110, 3'b011, 3'b111, 3'b001, 3'b100, 3'b000};
    logic [2:0]  lv_off [7] = '{3'd4, 3'd4, 3'd0, 3'd0, 3'd6, 3'd7, 3'd0};
    logic [63:0] lv_raw [7] = '{64'h87654321_00000000, 64'h87654321_00000000,
                                64'hDEADBEEF_CAFEF00D, 64'h80000000_00000001,
                                64'h8001_0000_0000_0000, 64'hF000_0000_0000_0000,
                                64'h0000_0000_0000_007F};
    logic [63:0] lv_exp [7] = '{64'hFFFFFFFF_87654321, 64'h00000000_87654321,
                                64'hDEADBEEF_CAFEF00D, 64'h80000000_00000001,
                                64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_00F0,
                                64'h0000_0000_0000_007F};

    initial begin
        rst_n        = 1'b0;
        mem_rd_i     = '0;
        mem_rd_wen_i = 1'b0;
        mem_funct3_i = '0;
        mem_off_i    = '0;
        mem_alu_i    = '0;
        mem_pc_i     = '0;
        ld_rdata_i   = '0;
        idle();

        // Reset state
        #12;
        chk("rst.wr_en", {63'd0, wr_en_o}, 64'd0);
        chk("rst.byp_valid", {63'd0, byp_valid_o}, 64'd0);
        chk("rst.wr_addr", {59'd0, wr_addr_o}, 64'd0);
        chk("rst.wr_data", wr_data_o, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst.ready", {63'd0, mem_ready_o}, 64'd1);
`ifdef WB_COMMIT_TRACE_EN
        chk("rst.instret", instret_o, 64'd0);
`endif

        // ALU writeback
        drive(5'd5, 1'b1, 1'b0, 3'd0, 3'd0, 64'h1234);
        tick();
        idle();
        chk_wr("alu", 1'b1, 5'd5, 64'h1234);
        chk("alu.ready", {63'd0, mem_ready_o}, 64'd1);
        tick();
        chk("alu.after", {63'd0, wr_en_o}, 64'd0);

        // Delayed LB rd=7 off=3
        drive(5'd7, 1'b1, 1'b1, 3'b000, 3'd3, 64'd0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("ldw.ready", {63'd0, mem_ready_o}, 64'd0);
            chk("ldw.wr_en", {63'd0, wr_en_o}, 64'd0);
            tick();
        end
        ld_rvalid_i = 1'b1;
        ld_rdata_i  = 64'h00000000_80000000;
        tick();
        ld_rvalid_i = 1'b0;
        chk_wr("ldw", 1'b1, 5'd7, 64'hFFFFFFFF_FFFFFF80);
        chk("ldw.ready_after", {63'd0, mem_ready_o}, 64'd1);
        tick();

        // Same-cycle LHU off=2
        drive(5'd9, 1'b1, 1'b1, 3'b101, 3'd2, 64'd0);
        ld_rvalid_i = 1'b1;
        ld_rdata_i  = 64'h0000_0000_ABCD_0000;
        tick();
        idle();
        chk_wr("lhu", 1'b1, 5'd9, 64'h0000_0000_0000_ABCD);
        tick();

        // Back-to-back ALU rd=1..4
        for (int i = 1; i <= 4; i++) begin
            drive(5'(i), 1'b1, 1'b0, 3'd0, 3'd0, 64'h11 * i);
            tick();
            chk_wr("b2b", 1'b1, 5'(i), 64'h11 * i);
            chk("b2b.ready", {63'd0, mem_ready_o}, 64'd1);
        end
        idle();
        tick();
        chk("b2b.drain", {63'd0, wr_en_o}, 64'd0);

        // Load formatting vectors, data with accept
        for (int i = 0; i < 7; i++) begin
            drive(5'd12, 1'b1, 1'b1, lv_f3[i], lv_off[i], 64'd0);
            ld_rvalid_i = 1'b1;
            ld_rdata_i  = lv_raw[i];
            tick();
            idle();
            chk_wr("fmt", 1'b1, 5'd12, lv_exp[i]);
        end
        tick();

        // rd_wen=0 produces no write
        drive(5'd3, 1'b0, 1'b0, 3'd0, 3'd0, 64'h55);
        tick();
        idle();
        chk_wr("nowen", 1'b0, 5'd3, 64'h55);
        tick();

        // x0 guard
        drive(5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'hFF);
        tick();
        idle();
        chk_wr("x0", 1'b0, 5'd0, 64'hFF);
`ifdef WB_COMMIT_TRACE_EN
        chk("x0.commit", {63'd0, commit_valid_o}, 64'd1);
        chk("x0.pc", commit_pc_o, 64'h1000);
        // ALU 1 + LB 1 + LHU 1 + b2b 4 + fmt 7 + nowen 1 already retired
        chk("x0.instret_pre", instret_o, 64'd15);
        tick();
        chk("x0.instret", instret_o, 64'd16);
        chk("x0.commit_off", {63'd0, commit_valid_o}, 64'd0);
`else
        tick();
`endif

        // Reset while WAIT_LD
        drive(5'd8, 1'b1, 1'b1, 3'b011, 3'd0, 64'd0);
        tick();
        idle();
        chk("rld.ready_wait", {63'd0, mem_ready_o}, 64'd0);
        #2;
        rst_n = 1'b0;
        #2;
        chk("rld.ready_rst", {63'd0, mem_ready_o}, 64'd1);
        chk("rld.wr_en_rst", {63'd0, wr_en_o}, 64'd0);
        chk("rld.wr_addr_rst", {59'd0, wr_addr_o}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rld.ready", {63'd0, mem_ready_o}, 64'd1);
        ld_rvalid_i = 1'b1;
        ld_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        tick();
        ld_rvalid_i = 1'b0;
        chk("rld.late", {63'd0, wr_en_o}, 64'd0);
        chk("rld.late_byp", {63'd0, byp_valid_o}, 64'd0);
        chk("rld.data", wr_data_o, 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the NPC pipeline; sits directly upstream of the register file write port (wr_addr/wr_data/wr_en).
- Accepts one retiring instruction per handshake from the memory stage, waits for late load data when required, then aligns and sign/zero-extends it.
- Drives one register write per instruction and mirrors that write on a bypass port for decode.

Parameters:
- XLEN, 64, datapath width (from defines.v)
- RADDR_W, 5, register address width (`reg_addr_width)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid_i  in  1  memory stage presents an instruction
- mem_ready_o  out  1  stage can accept an instruction
- mem_rd_i  in  RADDR_W  destination register
- mem_rd_wen_i  in  1  instruction writes rd
- mem_is_load_i  in  1  result comes from the load bus
- mem_funct3_i  in  3  load size/sign encoding
- mem_off_i  in  3  byte offset of the load within the 64-bit word
- mem_alu_i  in  XLEN  non-load result
- mem_pc_i  in  XLEN  instruction PC
- ld_rvalid_i  in  1  load data valid strobe
- ld_rdata_i  in  XLEN  raw 64-bit load word
- wr_addr_o  out  RADDR_W  regfile write address
- wr_data_o  out  XLEN  regfile write data
- wr_en_o  out  1  regfile write enable
- byp_valid_o  out  1  bypass valid (equals wr_en_o)
- byp_addr_o  out  RADDR_W  bypass address
- byp_data_o  out  XLEN  bypass data

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - state EMPTY.
  - All payload registers 0.
  - wr_en_o=0, byp_valid_o=0, wr_addr_o=0, wr_data_o=0.
  - mem_ready_o=1 once rst_n is high.
- Accept condition: mem_valid_i & mem_ready_o in cycle t. The payload is registered at the rising edge ending cycle t.
- States:
  - EMPTY: no entry held.
  - WAIT_LD: load held, data not yet received.
  - RDY: entry holds final result.
- Transitions:
  - EMPTY→RDY on accept of a non-load, or on accept of a load with ld_rvalid_i high in the same cycle (data captured with the accept).
  - EMPTY→WAIT_LD on accept of a load without ld_rvalid_i.
  - WAIT_LD→RDY on ld_rvalid_i; aligned and extended data captured.
  - RDY retires unconditionally in its cycle. It goes to RDY, WAIT_LD or EMPTY depending on a same-cycle accept.
- mem_ready_o = (state != WAIT_LD). Back-to-back accepts give one retire per cycle.
- Write outputs:
  - In RDY, wr_en_o = rd_wen & (rd != 0).
  - wr_addr_o and wr_data_o come combinationally from the entry registers.
  - Latency is 1 cycle after accept for non-loads, and 1 cycle after ld_rvalid_i for loads.
- Bypass port carries identical values to the write port in the same cycle.
- ld_rvalid_i is ignored in EMPTY and RDY unless it coincides with accepting a load.
- Load formatting:
  - Data = ld_rdata_i >> (8*mem_off_i).
  - Extension by funct3:
    - 000 LB: sign-extend bits[7:0]
    - 001 LH: sign-extend bits[15:0]
    - 010 LW: sign-extend bits[31:0]
    - 011 LD: full 64 bits
    - 100 LBU: zero-extend bits[7:0]
    - 101 LHU: zero-extend bits[15:0]
    - 110 LWU: zero-extend bits[31:0]
    - 111: treated as LD
  - Offset misalignment is not checked. Upper bytes shifted in are zero before extension.
- rd=0 with rd_wen=1: the instruction still retires, but wr_en_o and byp_valid_o stay 0.
- Reset asserted mid-operation drops any held entry immediately; outputs return to reset values.

Optional Feature:
- Macro: WB_COMMIT_TRACE_EN.
- Defined:
  - Adds ports commit_valid_o (1), commit_pc_o (XLEN) and instret_o (64).
  - commit_valid_o pulses for exactly the RDY retire cycle, including rd=0.
  - commit_pc_o holds the retiring PC.
  - instret_o increments by 1 on each retire; it resets to 0 and wraps modulo 2^64.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- defines.v additions:
  - Load funct3 constants: `LB … `LWU.
  - wb state encoding: `WB_EMPTY=2'd0, `WB_WAIT_LD=2'd1, `WB_RDY=2'd2.
- Existing defines reused: `XLEN and `reg_addr_width.
- One combinational sub-module, wb_load_align: inputs raw word, offset and funct3; output extended XLEN data.

Test Plan:
- ALU writeback: accept rd=5, alu=0x1234 → next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0x1234, byp mirrors it; mem_ready_o stays 1.
- Delayed load: accept LB rd=7, off=3; ld_rvalid_i 4 cycles later with rdata=0x00000000_80000000 → mem_ready_o=0 while waiting; next cycle wr_data_o=0xFFFFFFFF_FFFFFF80.
- Same-cycle load data: LHU off=2, rdata=0x0000_0000_ABCD_0000 with ld_rvalid_i at accept → next cycle wr_data_o=0x000000000000ABCD.
- Back-to-back: 4 consecutive ALU accepts rd=1..4 → 4 consecutive wr_en_o cycles in order, no bubbles.
- x0 guard: accept rd=0, rd_wen=1, alu=0xFF → wr_en_o=0, byp_valid_o=0. With WB_COMMIT_TRACE_EN, commit_valid_o=1 and instret_o increments.
- Reset mid-WAIT_LD: hold a load, pulse rst_n low → state EMPTY and mem_ready_o=1 after release; a late ld_rvalid_i produces no write.
